// File: rtl/bus_arb2x1.sv
// Purpose: round-robin arbiter letting two masters share one req/ack/resp slave
//          port, with an in-order tag FIFO that routes each read response back
//          to the master that issued the read.
// Latency: zero added cycles. Request and response paths are combinational.
// Backpressure: a master sees ack only when it is granted and the slave acks.
//          Reads are refused while RESP_DEPTH reads are outstanding; writes are
//          never refused by that limit.
//
// Ports:
//   clk_i, rst_i             clock, synchronous active-high reset
//   mN_req_i/we_i/addr_bi/   master N request fields (N = 0, 1)
//   be_bi/wdata_bi
//   mN_ack_o                 master N request accepted this cycle
//   mN_resp_o/rdata_bo       master N read data valid / read data
//   s_req_o/we_o/addr_bo/    slave request fields, taken from the granted master
//   be_bo/wdata_bo
//   s_ack_i                  slave accepted the request
//   s_resp_i/rdata_bi        slave read data valid / read data
//   err_o                    sticky: a response arrived with no read outstanding

// Purpose: generic synchronous FIFO with head peek and an occupancy count.
// Latency: a push is visible at the head on the cycle after it is written.
// Backpressure: a push into a full FIFO is dropped unless a pop happens in the
//          same cycle; a pop from an empty FIFO is ignored.
// Ports: push_vld/push_dat write side, pop_vld read side, head_dat is the
//        oldest entry, cnt/full/empty report occupancy.
module sync_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_vld,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop_vld,
  output logic [WIDTH-1:0]         head_dat,
  output logic [$clog2(DEPTH):0]   cnt,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (cnt == '0);
  assign full     = (cnt == CW'(DEPTH));
  assign do_pop   = pop_vld && !empty;
  // A pop in the same cycle frees the slot the push needs.
  assign do_push  = push_vld && (!full || do_pop);
  assign head_dat = mem[rd_ptr];

  // Storage carries no reset: entries are only read when cnt says they are valid.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// Purpose: two-master to one-slave round-robin bus arbiter with read-response
//          routing through an in-order owner tag FIFO.
// Latency: combinational request, ack and response paths (zero added cycles).
// Backpressure: ungranted masters and reads blocked by a full tag FIFO see
//          ack=0 and must hold their request.
module bus_arb2x1 #(
  parameter int RESP_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic        m0_req_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_addr_bi,
  input  logic [3:0]  m0_be_bi,
  input  logic [31:0] m0_wdata_bi,
  output logic        m0_ack_o,
  output logic        m0_resp_o,
  output logic [31:0] m0_rdata_bo,

  input  logic        m1_req_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_addr_bi,
  input  logic [3:0]  m1_be_bi,
  input  logic [31:0] m1_wdata_bi,
  output logic        m1_ack_o,
  output logic        m1_resp_o,
  output logic [31:0] m1_rdata_bo,

  output logic        s_req_o,
  output logic        s_we_o,
  output logic [31:0] s_addr_bo,
  output logic [3:0]  s_be_bo,
  output logic [31:0] s_wdata_bo,
  input  logic        s_ack_i,
  input  logic        s_resp_i,
  input  logic [31:0] s_rdata_bi,

  output logic        err_o
);

  localparam int CW = $clog2(RESP_DEPTH) + 1;

  // Round-robin state: the master granted most recently. Resets to 1 so
  // master 0 wins the first conflict.
  logic          last_q;
  logic          err_q;

  logic          m0_elig;
  logic          m1_elig;
  logic          grant_vld;
  logic          grant_sel;
  logic          accept;

  logic          tag_push;
  logic          tag_pop;
  logic          tag_head;
  logic          tag_full;
  logic          tag_empty;
  logic [CW-1:0] tag_cnt;

  // Blocking looks only at the registered count. A response popping the FIFO
  // this cycle does not unblock a read until the next cycle, which keeps
  // s_resp_i out of the ack path.
  assign m0_elig   = m0_req_i && (m0_we_i || !tag_full);
  assign m1_elig   = m1_req_i && (m1_we_i || !tag_full);
  assign grant_vld = m0_elig || m1_elig;

  always_comb begin
    grant_sel = 1'b0;
    if (m0_elig && m1_elig) begin
      grant_sel = ~last_q;
    end else begin
      grant_sel = m1_elig;
    end
  end

  // Slave request mux: all fields forced to zero when nobody is granted.
  always_comb begin
    s_req_o    = 1'b0;
    s_we_o     = 1'b0;
    s_addr_bo  = '0;
    s_be_bo    = '0;
    s_wdata_bo = '0;
    if (grant_vld) begin
      s_req_o = 1'b1;
      if (grant_sel) begin
        s_we_o     = m1_we_i;
        s_addr_bo  = m1_addr_bi;
        s_be_bo    = m1_be_bi;
        s_wdata_bo = m1_wdata_bi;
      end else begin
        s_we_o     = m0_we_i;
        s_addr_bo  = m0_addr_bi;
        s_be_bo    = m0_be_bi;
        s_wdata_bo = m0_wdata_bi;
      end
    end
  end

  assign accept   = grant_vld && s_ack_i;
  assign m0_ack_o = accept && !grant_sel;
  assign m1_ack_o = accept &&  grant_sel;

  // Only reads expect a response, so only reads record their owner.
  assign tag_push = accept && !s_we_o;

  // A response with nothing outstanding is dropped and flagged, never popped.
  assign tag_pop  = s_resp_i && !tag_empty;

  sync_fifo #(
    .WIDTH (1),
    .DEPTH (RESP_DEPTH)
  ) u_tag_fifo (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .push_vld (tag_push),
    .push_dat (grant_sel),
    .pop_vld  (tag_pop),
    .head_dat (tag_head),
    .cnt      (tag_cnt),
    .full     (tag_full),
    .empty    (tag_empty)
  );

  assign m0_resp_o   = tag_pop && !tag_head;
  assign m1_resp_o   = tag_pop &&  tag_head;
  assign m0_rdata_bo = s_rdata_bi;
  assign m1_rdata_bo = s_rdata_bi;
  assign err_o       = err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q <= 1'b1;
      err_q  <= 1'b0;
    end else begin
      if (accept) begin
        last_q <= grant_sel;
      end
      if (s_resp_i && tag_empty) begin
        err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bus_arb2x1.sv
// Purpose: directed bench for bus_arb2x1 with a read-response scoreboard.
// Latency: expects zero added latency; the bench slave responds one cycle after ack.
// Backpressure: bench slave always acks when told to; responses can be withheld.
module tb_bus_arb2x1;

  localparam int DEPTH = 4;

  logic        clk_i;
  logic        rst_i;
  logic        m0_req_i, m0_we_i, m1_req_i, m1_we_i;
  logic [31:0] m0_addr_bi, m0_wdata_bi, m1_addr_bi, m1_wdata_bi;
  logic [3:0]  m0_be_bi, m1_be_bi;
  logic        m0_ack_o, m0_resp_o, m1_ack_o, m1_resp_o;
  logic [31:0] m0_rdata_bo, m1_rdata_bo;
  logic        s_req_o, s_we_o;
  logic [31:0] s_addr_bo, s_wdata_bo;
  logic [3:0]  s_be_bo;
  logic        s_ack_i, s_resp_i;
  logic [31:0] s_rdata_bi;
  logic        err_o;

  bus_arb2x1 #(.RESP_DEPTH(DEPTH)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .m0_req_i    (m0_req_i),
    .m0_we_i     (m0_we_i),
    .m0_addr_bi  (m0_addr_bi),
    .m0_be_bi    (m0_be_bi),
    .m0_wdata_bi (m0_wdata_bi),
    .m0_ack_o    (m0_ack_o),
    .m0_resp_o   (m0_resp_o),
    .m0_rdata_bo (m0_rdata_bo),
    .m1_req_i    (m1_req_i),
    .m1_we_i     (m1_we_i),
    .m1_addr_bi  (m1_addr_bi),
    .m1_be_bi    (m1_be_bi),
    .m1_wdata_bi (m1_wdata_bi),
    .m1_ack_o    (m1_ack_o),
    .m1_resp_o   (m1_resp_o),
    .m1_rdata_bo (m1_rdata_bo),
    .s_req_o     (s_req_o),
    .s_we_o      (s_we_o),
    .s_addr_bo   (s_addr_bo),
    .s_be_bo     (s_be_bo),
    .s_wdata_bo  (s_wdata_bo),
    .s_ack_i     (s_ack_i),
    .s_resp_i    (s_resp_i),
    .s_rdata_bi  (s_rdata_bi),
    .err_o       (err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    bit          m;
    logic [31:0] dat;
  } exp_t;

  exp_t        exp_q[$];     // expected responses, in issue order
  logic [31:0] slv_q[$];     // data the bench slave still owes
  int          obs_grants[$];
  int          obs_resps[$];

  int checks   = 0;
  int failures = 0;

  bit m_last;
  bit m_err;
  bit resp_auto;
  int resp_release;
  bit resp_spurious;

  function automatic logic [31:0] slave_data(input logic [31:0] addr);
    if (addr == 32'h100) return 32'hDEAD_BEEF;
    return addr ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_masters();
    m0_req_i = 0; m0_we_i = 0; m0_addr_bi = '0; m0_be_bi = '0; m0_wdata_bi = '0;
    m1_req_i = 0; m1_we_i = 0; m1_addr_bi = '0; m1_be_bi = '0; m1_wdata_bi = '0;
  endtask

  // One bus cycle: drive the bench slave response, check every output against
  // the reference model at the falling edge, then update the model.
  task automatic run_cycle();
    bit full, e0, e1, gv, gs, er0, er1;
    logic        x_we;
    logic [31:0] x_addr, x_wdata;
    logic [3:0]  x_be;
    exp_t        e;

    if (slv_q.size() > 0 && (resp_auto || resp_release > 0)) begin
      s_resp_i   = 1;
      s_rdata_bi = slv_q.pop_front();
      if (!resp_auto) resp_release--;
    end else if (resp_spurious) begin
      s_resp_i      = 1;
      s_rdata_bi    = 32'hBAD0_BAD0;
      resp_spurious = 0;
    end else begin
      s_resp_i   = 0;
      s_rdata_bi = '0;
    end

    @(negedge clk_i);

    full = (exp_q.size() == DEPTH);
    e0   = m0_req_i && (m0_we_i || !full);
    e1   = m1_req_i && (m1_we_i || !full);
    gv   = e0 || e1;
    gs   = (e0 && e1) ? !m_last : e1;
    x_we = 0; x_addr = '0; x_be = '0; x_wdata = '0;
    if (gv) begin
      x_we    = gs ? m1_we_i     : m0_we_i;
      x_addr  = gs ? m1_addr_bi  : m0_addr_bi;
      x_be    = gs ? m1_be_bi    : m0_be_bi;
      x_wdata = gs ? m1_wdata_bi : m0_wdata_bi;
    end

    chk("s_req",   s_req_o,    gv);
    chk("s_we",    s_we_o,     x_we);
    chk("s_addr",  s_addr_bo,  x_addr);
    chk("s_be",    s_be_bo,    x_be);
    chk("s_wdata", s_wdata_bo, x_wdata);
    chk("m0_ack",  m0_ack_o,   gv && !gs && s_ack_i);
    chk("m1_ack",  m1_ack_o,   gv &&  gs && s_ack_i);

    er0 = 0; er1 = 0;
    if (s_resp_i) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.m) begin
          er1 = 1;
          chk("m1_rdata", m1_rdata_bo, e.dat);
        end else begin
          er0 = 1;
          chk("m0_rdata", m0_rdata_bo, e.dat);
        end
      end else begin
        m_err = 1;
      end
    end
    chk("m0_resp", m0_resp_o, er0);
    chk("m1_resp", m1_resp_o, er1);

    if (m0_ack_o) obs_grants.push_back(0);
    if (m1_ack_o) obs_grants.push_back(1);
    if (m0_resp_o) obs_resps.push_back(0);
    if (m1_resp_o) obs_resps.push_back(1);

    if (gv && s_ack_i) begin
      m_last = gs;
      if (!x_we) begin
        e.m   = gs;
        e.dat = slave_data(x_addr);
        exp_q.push_back(e);
        slv_q.push_back(e.dat);
      end
    end

    @(posedge clk_i);
    #1;
    chk("err", err_o, m_err);
  endtask

  task automatic do_reset();
    idle_masters();
    s_ack_i    = 0;
    s_resp_i   = 0;
    s_rdata_bi = '0;
    rst_i      = 1;
    @(posedge clk_i);
    #1;
    rst_i = 0;
    m_last = 1;
    m_err  = 0;
    exp_q.delete();
    slv_q.delete();
    obs_grants.delete();
    obs_resps.delete();
    resp_release  = 0;
    resp_spurious = 0;
  endtask

  initial begin
    rst_i = 1;
    resp_auto = 1;
    do_reset();

    // Reset state: every output idle, internal registers at their reset values.
    chk("rst_cnt",  dut.tag_cnt, 0);
    chk("rst_last", dut.last_q, 1);
    run_cycle();

    // Single read from master 0.
    s_ack_i = 1;
    m0_req_i = 1; m0_addr_bi = 32'h100; m0_be_bi = 4'hF;
    run_cycle();
    idle_masters();
    run_cycle();
    run_cycle();
    chk("t1_resps", obs_resps.size(), 1);

    // Contention: both masters read continuously.
    do_reset();
    resp_auto = 1;
    s_ack_i = 1;
    m0_req_i = 1; m0_addr_bi = 32'h200; m0_be_bi = 4'hF;
    m1_req_i = 1; m1_addr_bi = 32'h300; m1_be_bi = 4'h3;
    for (int i = 0; i < 4; i++) run_cycle();
    idle_masters();
    run_cycle();
    run_cycle();
    chk("t2_grant_n", obs_grants.size(), 4);
    chk("t2_resp_n",  obs_resps.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < obs_grants.size()) chk("t2_grant_order", obs_grants[i], i % 2);
      if (i < obs_resps.size())  chk("t2_resp_order",  obs_resps[i],  i % 2);
    end

    // FIFO full: responses withheld, master 0 keeps reading.
    do_reset();
    resp_auto = 0;
    s_ack_i = 1;
    m0_req_i = 1; m0_addr_bi = 32'h400; m0_be_bi = 4'hF;
    for (int i = 0; i < 5; i++) run_cycle();
    chk("t3_acks_full", obs_grants.size(), 4);
    chk("t3_cnt_full",  dut.tag_cnt, 4);
    m1_req_i = 1; m1_we_i = 1; m1_addr_bi = 32'h44; m1_be_bi = 4'hF; m1_wdata_bi = 32'hCAFE_0001;
    run_cycle();
    chk("t3_wr_while_full", (obs_grants.size() == 5) ? obs_grants[4] : 9, 1);
    m1_req_i = 0; m1_we_i = 0;
    resp_release = 1;
    run_cycle();  // response pops, but the read stays blocked this cycle
    chk("t3_blocked_on_pop", obs_grants.size(), 5);
    run_cycle();  // fifth read accepted now
    chk("t3_fifth_read", obs_grants.size(), 6);
    idle_masters();
    resp_auto = 1;
    for (int i = 0; i < 6; i++) run_cycle();
    chk("t3_drain", obs_resps.size(), 5);

    // Write from master 1, then a spurious response.
    do_reset();
    resp_auto = 1;
    s_ack_i = 1;
    m1_req_i = 1; m1_we_i = 1; m1_addr_bi = 32'h40; m1_be_bi = 4'hF; m1_wdata_bi = 32'h1234_5678;
    run_cycle();
    idle_masters();
    chk("t4_cnt", dut.tag_cnt, 0);
    resp_spurious = 1;
    run_cycle();
    chk("t4_err", err_o, 1);
    chk("t4_no_resp", obs_resps.size(), 0);

    // Mixed routing.
    do_reset();
    resp_auto = 1;
    s_ack_i = 1;
    m0_req_i = 1; m0_addr_bi = 32'h500; m0_be_bi = 4'hF;
    run_cycle();
    idle_masters();
    m1_req_i = 1; m1_addr_bi = 32'h600; m1_be_bi = 4'hF;
    run_cycle();
    idle_masters();
    m0_req_i = 1; m0_we_i = 1; m0_addr_bi = 32'h504; m0_be_bi = 4'h1; m0_wdata_bi = 32'h0000_00AA;
    run_cycle();
    idle_masters();
    m1_req_i = 1; m1_addr_bi = 32'h700; m1_be_bi = 4'hC;
    run_cycle();
    idle_masters();
    for (int i = 0; i < 3; i++) run_cycle();
    chk("t5_resp_n", obs_resps.size(), 3);
    if (obs_resps.size() == 3) begin
      chk("t5_resp0", obs_resps[0], 0);
      chk("t5_resp1", obs_resps[1], 1);
      chk("t5_resp2", obs_resps[2], 1);
    end

    // Reset with three reads outstanding.
    do_reset();
    resp_auto = 0;
    s_ack_i = 1;
    m1_req_i = 1; m1_addr_bi = 32'h800; m1_be_bi = 4'hF;
    for (int i = 0; i < 3; i++) run_cycle();
    chk("t6_cnt_pre", dut.tag_cnt, 3);
    do_reset();
    chk("t6_cnt",  dut.tag_cnt, 0);
    chk("t6_err",  err_o, 0);
    chk("t6_last", dut.last_q, 1);
    s_ack_i = 1;
    m0_req_i = 1; m0_addr_bi = 32'h900; m0_be_bi = 4'hF;
    m1_req_i = 1; m1_addr_bi = 32'hA00; m1_be_bi = 4'hF;
    run_cycle();
    chk("t6_first_grant", (obs_grants.size() > 0) ? obs_grants[0] : 9, 0);
    idle_masters();
    resp_auto = 1;
    run_cycle();
    run_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
